// File: rtl/note_recorder_if.sv
// note_recorder_if -- bus between the mode/keyboard side and the note recorder.
//   mode     : system mode (3'b100 record, 3'b101 replay, else idle)
//   key_note : live note code from keyboard decode (0 = silence)
//   note     : registered note code to the buzzer driver
//   rec_len  : number of valid stored slots
//   full     : recording stopped because memory filled
//   state    : recorder FSM state (00 idle, 01 rec, 10 play)
// master = controller/testbench side, slave = recorder side.
interface note_recorder_if;
  logic [2:0] mode;
  logic [4:0] key_note;
  logic [4:0] note;
  logic [6:0] rec_len;
  logic       full;
  logic [1:0] state;

  modport master (output mode, key_note, input note, rec_len, full, state);
  modport slave  (input mode, key_note, output note, rec_len, full, state);
endinterface

// File: rtl/note_recorder.sv
// note_recorder -- records one keyboard note per beat slot into a small memory
// and replays the stored sequence in a loop with a muted articulation gap at
// the end of every slot.
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : note_recorder_if.slave (mode, key_note in; note, rec_len, full, state out)
// Parameters: PERIOD cycles per slot, GAP mute index within a slot, DEPTH slots.
module note_recorder #(
  parameter int PERIOD = 50000000,
  parameter int GAP    = 9*PERIOD/10,
  parameter int DEPTH  = 64
) (
  input logic            clk,
  input logic            rst_n,
  note_recorder_if.slave bus
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(PERIOD-1);
  localparam logic [CW-1:0] BEAT_GAP  = CW'(GAP);
  localparam logic [6:0]    LEN_LAST  = 7'(DEPTH-1);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_REC = 2'b01, S_PLAY = 2'b10} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   beat;
  logic [5:0]      rd_ptr;
  logic [6:0]      rec_len;
  logic            full;
  logic            halted;   // memory filled while mode still says record
  logic [4:0]      note_q;
  logic [4:0]      mem [DEPTH];

  logic rec_mode, play_mode, tick, last_wr;

  assign rec_mode  = (bus.mode == 3'b100);
  assign play_mode = (bus.mode == 3'b101);
  assign tick      = (state_q != S_IDLE) && (beat == BEAT_LAST);
  // Slot write that fills the memory; it also ends the recording.
  assign last_wr   = (state_q == S_REC) && tick && (rec_len == LEN_LAST);

  always_comb begin
    state_d = S_IDLE;
    if (play_mode)
      state_d = S_PLAY;
    else if (rec_mode && !halted && !last_wr)
      state_d = S_REC;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat    <= '0;
      rd_ptr  <= '0;
      rec_len <= '0;
      full    <= 1'b0;
      halted  <= 1'b0;
      note_q  <= '0;
    end else begin
      case (state_q)
        S_REC:   note_q <= bus.key_note;
        S_PLAY:  note_q <= (rec_len != 7'd0 && beat < BEAT_GAP) ? mem[rd_ptr[AW-1:0]] : 5'd0;
        default: note_q <= 5'd0;
      endcase

      // The halt only lasts until mode leaves record; a fresh record entry re-arms.
      if (!rec_mode)    halted <= 1'b0;
      else if (last_wr) halted <= 1'b1;

      if (state_q == S_REC && tick) begin
        rec_len <= rec_len + 7'd1;
        if (last_wr) full <= 1'b1;
      end

      if (state_q == S_PLAY && tick && rec_len != 7'd0)
        rd_ptr <= ({1'b0, rd_ptr} == rec_len - 7'd1) ? 6'd0 : rd_ptr + 6'd1;

      // Entry actions take priority over the in-state updates above.
      if (state_d != state_q) begin
        beat <= '0;
        if (state_d == S_REC) begin
          rec_len <= '0;
          full    <= 1'b0;
        end
        if (state_d == S_PLAY) rd_ptr <= '0;
      end else if (state_q != S_IDLE) begin
        beat <= tick ? '0 : beat + 1'b1;
      end
    end
  end

  // Write pointer always equals rec_len while recording, so rec_len addresses
  // the next free slot directly.
  always_ff @(posedge clk)
    if (state_q == S_REC && tick)
      mem[rec_len[AW-1:0]] <= bus.key_note;

  assign bus.note    = note_q;
  assign bus.rec_len = rec_len;
  assign bus.full    = full;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder -- directed scenarios plus randomized mode/key traffic for
// note_recorder (PERIOD=10, GAP=9, DEPTH=4), checked every cycle against a
// queue-based behavioural model.
module tb_note_recorder;
  localparam int P = 10, G = 9, D = 4;

  logic clk, rst_n;
  note_recorder_if bus();

  note_recorder #(.PERIOD(P), .GAP(G), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the recording is a queue of notes; mode 0 idle, 1 rec, 2 play.
  int m_st, m_beat, m_rd, m_full, m_halt, m_note;
  int q[$];

  function automatic void model_reset();
    m_st = 0; m_beat = 0; m_rd = 0; m_full = 0; m_halt = 0; m_note = 0;
    q.delete();
  endfunction

  function automatic void model_step(input int md, input int key);
    int tick, nxt, fillup;
    tick = (m_st != 0 && m_beat == P-1) ? 1 : 0;
    if (m_st == 1)                                    m_note = key;
    else if (m_st == 2 && q.size() > 0 && m_beat < G) m_note = q[m_rd];
    else                                              m_note = 0;
    fillup = 0;
    if (m_st == 1 && tick == 1) begin
      q.push_back(key);
      if (q.size() == D) begin m_full = 1; fillup = 1; end
    end
    if (m_st == 2 && tick == 1 && q.size() > 0) m_rd = (m_rd + 1) % q.size();
    if (md == 5)                                        nxt = 2;
    else if (md == 4 && m_halt == 0 && fillup == 0)     nxt = 1;
    else                                                nxt = 0;
    m_halt = (md != 4) ? 0 : (fillup == 1 ? 1 : m_halt);
    if (nxt != m_st) begin
      m_beat = 0;
      if (nxt == 1) begin q.delete(); m_full = 0; end
      if (nxt == 2) m_rd = 0;
    end else if (m_st != 0) begin
      m_beat = (m_beat + 1) % P;
    end
    m_st = nxt;
  endfunction

  // Called at a negedge: drive inputs, clock once, step model, compare at next negedge.
  task automatic run_cycle(input int md, input int key);
    bus.mode = 3'(md);
    bus.key_note = 5'(key);
    @(posedge clk);
    model_step(md, key);
    @(negedge clk);
    chk("note",  bus.note,    m_note);
    chk("len",   bus.rec_len, q.size());
    chk("full",  bus.full,    m_full);
    chk("state", bus.state,   m_st);
  endtask

  // Asynchronous reset between clock edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_note",  bus.note,    0);
    chk("rst_len",   bus.rec_len, 0);
    chk("rst_full",  bus.full,    0);
    chk("rst_state", bus.state,   0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k, md, seg, r;
    int arr3 [3] = '{5, 0, 12};
    rst_n = 1'b0;
    bus.mode = 3'd0;
    bus.key_note = 5'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_note",  bus.note,    0);
    chk("init_len",   bus.rec_len, 0);
    chk("init_full",  bus.full,    0);
    chk("init_state", bus.state,   0);
    rst_n = 1'b1;

    // Record 5,0,12 over three slots, then go idle.
    for (int i = 0; i < 31; i++) run_cycle(4, arr3[(i == 0) ? 0 : (i-1)/10]);
    run_cycle(0, 0);
    chk("rec3_len",  bus.rec_len, 3);
    chk("rec3_full", bus.full,    0);
    run_cycle(0, 0);

    // Replay; reset lands at cycle 7 of the second slot.
    run_cycle(5, 0);
    run_cycle(5, 0);
    chk("play_first", bus.note, 5);
    for (int i = 0; i < 16; i++) run_cycle(5, 0);
    do_reset();

    // Record keys 1..6 over six slots; memory fills after the fourth.
    for (int i = 0; i < 61; i++) run_cycle(4, (i == 0) ? 1 : (i-1)/10 + 1);
    chk("fill_len",   bus.rec_len, 4);
    chk("fill_full",  bus.full,    1);
    chk("fill_state", bus.state,   0);
    run_cycle(0, 0);
    for (int i = 0; i < 50; i++) run_cycle(5, 0);

    // Replay with nothing recorded.
    do_reset();
    for (int i = 0; i < 50; i++) run_cycle(5, 0);
    chk("empty_state", bus.state, 2);
    chk("empty_note",  bus.note,  0);

    // Record two slots, replay, then jump straight into record mid-slot.
    for (int i = 0; i < 21; i++) run_cycle(4, 7 + i/10);
    for (int i = 0; i < 15; i++) run_cycle(5, 0);
    run_cycle(4, 3);
    chk("sw_state", bus.state,   1);
    chk("sw_len",   bus.rec_len, 0);
    chk("sw_full",  bus.full,    0);
    for (int i = 0; i < 9; i++) run_cycle(4, 3);
    chk("sw_len9",  bus.rec_len, 0);
    run_cycle(4, 3);
    chk("sw_len10", bus.rec_len, 1);

    // Randomized mode segments with occasional resets.
    k = 0;
    for (seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      md = 0;
      else if (r < 6) md = 4;
      else if (r < 9) md = 5;
      else begin
        md = $urandom_range(0, 7);
        if (md == 4 || md == 5) md = 6;
      end
      if ($urandom_range(0, 14) == 0) do_reset();
      for (int i = 0, n = $urandom_range(1, 70); i < n; i++) begin
        if ($urandom_range(0, 7) == 0) k = $urandom_range(0, 31);
        run_cycle(md, k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
